// File: rtl/serial_shift_detector.sv
// rtl/serial_shift_detector.sv - serial-in shift register with pattern matcher and saturating match counter
module serial_shift_detector #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             dir,
  input  logic             clear,
  input  logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] r,
  output logic             full,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [WIDTH-1:0]  r_next;
  logic              hit;

  // Matching looks at the state the register will hold after this shift,
  // so match lines up with r showing the matching value.
  always_comb begin
    r_next    = dir ? {a, r[WIDTH-1:1]} : {r[WIDTH-2:0], a};
    fill_next = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
    hit       = (fill_next == FILL_MAX) && (r_next == pattern);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r           <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (en) begin
      r     <= r_next;
      match <= hit;
      // Non-overlapping mode forgets the bit history once a match is taken.
      if (hit && (OVERLAP == 0))
        fill <= '0;
      else
        fill <= fill_next;
      if (hit && (match_count != CNT_MAX))
        match_count <= match_count + CNT_W'(1);
    end else begin
      match <= 1'b0;
    end
  end

  assign full = (fill == FILL_MAX);

endmodule

// File: tb/tb_serial_shift_detector.sv
// tb/tb_serial_shift_detector.sv - directed self-checking bench for serial_shift_detector
module tb_serial_shift_detector;

  logic       clk = 1'b0;
  logic       reset, en, a, dir, clear;
  logic [3:0] pattern;

  logic [3:0] r0, r1, r2;
  logic       full0, full1, full2;
  logic       match0, match1, match2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_shift_detector #(.WIDTH(4), .CNT_W(8), .OVERLAP(1)) dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .dir(dir), .clear(clear),
    .pattern(pattern), .r(r0), .full(full0), .match(match0), .match_count(cnt0)
  );

  serial_shift_detector #(.WIDTH(4), .CNT_W(8), .OVERLAP(0)) dut_no (
    .clk(clk), .reset(reset), .en(en), .a(a), .dir(dir), .clear(clear),
    .pattern(pattern), .r(r1), .full(full1), .match(match1), .match_count(cnt1)
  );

  serial_shift_detector #(.WIDTH(4), .CNT_W(2), .OVERLAP(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .a(a), .dir(dir), .clear(clear),
    .pattern(pattern), .r(r2), .full(full2), .match(match2), .match_count(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; en = 1'b0; a = 1'b0; dir = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic shift(input logic bit_a);
    a  = bit_a;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    pattern = 4'b0000;
    do_reset();
    n_cmp++;
    if ({r0, full0, match0, cnt0} !== 14'd0) begin
      n_bad++; $display("FAIL reset_dut got r=%b full=%b match=%b cnt=%0d exp all 0", r0, full0, match0, cnt0);
    end
    n_cmp++;
    if ({r1, full1, match1, cnt1, r2, full2, match2, cnt2} !== 22'd0) begin
      n_bad++; $display("FAIL reset_others got r1=%b r2=%b cnt1=%0d cnt2=%0d exp 0", r1, r2, cnt1, cnt2);
    end
  endtask

  task automatic test_ones_overlap();
    logic [3:0] er [0:14];
    logic       ef [0:14];
    logic       em [0:14];
    er = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    ef = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    em = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    pattern = 4'b1111;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      shift(i >= 5);
      n_cmp++;
      if (r0 !== er[i] || full0 !== ef[i] || match0 !== em[i]) begin
        n_bad++;
        $display("FAIL ones[%0d] got r=%b full=%b match=%b exp r=%b full=%b match=%b",
                 i, r0, full0, match0, er[i], ef[i], em[i]);
      end
    end
    n_cmp++;
    if (cnt0 !== 8'd7) begin
      n_bad++; $display("FAIL ones_count got %0d exp 7", cnt0);
    end
  endtask

  task automatic test_zero_pattern();
    logic em [0:4];
    em = '{0, 0, 0, 1, 1};
    pattern = 4'b0000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      shift(1'b0);
      n_cmp++;
      if (match0 !== em[i]) begin
        n_bad++; $display("FAIL zeros_match[%0d] got %b exp %b", i, match0, em[i]);
      end
    end
    n_cmp++;
    if (cnt0 !== 8'd2) begin
      n_bad++; $display("FAIL zeros_count got %0d exp 2", cnt0);
    end
  endtask

  task automatic test_direction();
    logic       bl [0:3];
    logic [3:0] rl [0:3];
    logic       br [0:3];
    logic [3:0] rr [0:3];
    bl = '{1, 0, 1, 1};
    rl = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    br = '{1, 1, 0, 0};
    rr = '{4'b1000, 4'b1100, 4'b0110, 4'b0011};
    pattern = 4'b1011;
    do_reset();
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift(bl[i]);
      n_cmp++;
      if (r0 !== rl[i] || match0 !== (i == 3)) begin
        n_bad++; $display("FAIL left[%0d] got r=%b match=%b exp r=%b match=%b", i, r0, match0, rl[i], (i == 3));
      end
    end
    n_cmp++;
    if (cnt0 !== 8'd1) begin
      n_bad++; $display("FAIL left_count got %0d exp 1", cnt0);
    end
    pattern = 4'b0011;
    do_reset();
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      shift(br[i]);
      n_cmp++;
      if (r0 !== rr[i] || match0 !== (i == 3)) begin
        n_bad++; $display("FAIL right[%0d] got r=%b match=%b exp r=%b match=%b", i, r0, match0, rr[i], (i == 3));
      end
    end
    dir = 1'b0;
  endtask

  task automatic test_overlap_modes();
    logic       bits [0:5];
    logic [3:0] er   [0:5];
    logic       em0  [0:5];
    logic       em1  [0:5];
    logic       ef1  [0:5];
    bits = '{1, 0, 1, 0, 1, 0};
    er   = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0101, 4'b1010};
    em0  = '{0, 0, 0, 1, 0, 1};
    em1  = '{0, 0, 0, 1, 0, 0};
    ef1  = '{0, 0, 0, 0, 0, 0};
    pattern = 4'b1010;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      shift(bits[i]);
      n_cmp++;
      if (r0 !== er[i] || match0 !== em0[i]) begin
        n_bad++; $display("FAIL ovl1[%0d] got r=%b match=%b exp r=%b match=%b", i, r0, match0, er[i], em0[i]);
      end
      n_cmp++;
      if (r1 !== er[i] || match1 !== em1[i] || full1 !== ef1[i]) begin
        n_bad++;
        $display("FAIL ovl0[%0d] got r=%b match=%b full=%b exp r=%b match=%b full=%b",
                 i, r1, match1, full1, er[i], em1[i], ef1[i]);
      end
    end
    n_cmp++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd1) begin
      n_bad++; $display("FAIL ovl_counts got %0d/%0d exp 2/1", cnt0, cnt1);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ec [0:7];
    logic       em [0:7];
    ec = '{0, 0, 0, 1, 2, 3, 3, 3};
    em = '{0, 0, 0, 1, 1, 1, 1, 1};
    pattern = 4'b1111;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      shift(1'b1);
      n_cmp++;
      if (cnt2 !== ec[i] || match2 !== em[i]) begin
        n_bad++; $display("FAIL sat[%0d] got cnt=%0d match=%b exp cnt=%0d match=%b", i, cnt2, match2, ec[i], em[i]);
      end
    end
  endtask

  task automatic test_clear();
    pattern = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) shift(1'b1);
    a = 1'b1; en = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b0;
    n_cmp++;
    if ({r0, full0, match0, cnt0} !== 14'd0) begin
      n_bad++; $display("FAIL clear got r=%b full=%b match=%b cnt=%0d exp all 0", r0, full0, match0, cnt0);
    end
    for (int i = 0; i < 3; i++) shift(1'b1);
    n_cmp++;
    if (match0 !== 1'b0 || r0 !== 4'b0111) begin
      n_bad++; $display("FAIL clear_refill got r=%b match=%b exp r=0111 match=0", r0, match0);
    end
    shift(1'b1);
    n_cmp++;
    if (match0 !== 1'b1 || cnt0 !== 8'd1) begin
      n_bad++; $display("FAIL clear_first got match=%b cnt=%0d exp 1/1", match0, cnt0);
    end
    shift(1'b1);
    a = 1'b1; en = 1'b1; clear = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0; en = 1'b0;
    n_cmp++;
    if ({r0, full0, match0, cnt0} !== 14'd0) begin
      n_bad++; $display("FAIL reset_clear got r=%b full=%b match=%b cnt=%0d exp all 0", r0, full0, match0, cnt0);
    end
  endtask

  task automatic test_enable_gap();
    pattern = 4'b1011;
    do_reset();
    shift(1'b1);
    shift(1'b0);
    for (int i = 0; i < 3; i++) begin
      a = ~a; en = 1'b0;
      tick();
      n_cmp++;
      if (r0 !== 4'b0010 || match0 !== 1'b0 || full0 !== 1'b0) begin
        n_bad++; $display("FAIL gap_hold[%0d] got r=%b match=%b full=%b exp 0010/0/0", i, r0, match0, full0);
      end
    end
    shift(1'b1);
    shift(1'b1);
    n_cmp++;
    if (r0 !== 4'b1011 || match0 !== 1'b1 || cnt0 !== 8'd1) begin
      n_bad++; $display("FAIL gap_match got r=%b match=%b cnt=%0d exp 1011/1/1", r0, match0, cnt0);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if (match0 !== 1'b0 || cnt0 !== 8'd1) begin
      n_bad++; $display("FAIL gap_idle got match=%b cnt=%0d exp 0/1", match0, cnt0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; a = 1'b0; dir = 1'b0; clear = 1'b0; pattern = 4'b0000;
    test_reset();
    test_ones_overlap();
    test_zero_pattern();
    test_direction();
    test_overlap_modes();
    test_saturation();
    test_clear();
    test_enable_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
